// File: rtl/ahb_ap_resp_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_ap_resp_buf_if
// Purpose  : Bundles the signals between the AHB access point, the response
//            buffer and the JTAG DR-capture logic.
// Ports    : winc/wdata_fifo2  push side (from AP)
//            rinc              pop side (from DR-capture)
//            rdata             {ack[1:0], tag, data} of the head entry
//            rempty/wfull/count occupancy status
//            overflow/drop_cnt/clr_overflow  drop reporting and clear
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_ap_resp_buf_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
);
  logic                       winc;
  logic [DATA_W-1:0]          wdata_fifo2;
  logic                       rinc;
  logic [DATA_W+TAG_W+1:0]    rdata;
  logic                       rempty;
  logic                       wfull;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic [7:0]                 drop_cnt;
  logic                       clr_overflow;

  // AP / DR-capture side: drives requests, observes status.
  modport master (
    output winc, wdata_fifo2, rinc, clr_overflow,
    input  rdata, rempty, wfull, count, overflow, drop_cnt
  );

  // Buffer side.
  modport slave (
    input  winc, wdata_fifo2, rinc, clr_overflow,
    output rdata, rempty, wfull, count, overflow, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ahb_ap_resp_buf.sv
`default_nettype none
// ============================================================================
// Module   : ahb_ap_resp_buf
// Purpose  : In-order response buffer behind the AHB access point. Each pushed
//            read result is stored with a wrapping sequence tag and an ack code
//            (2'b01 OK, 2'b11 "a push was dropped before this one"). The head
//            entry is presented first-word-fall-through; when empty, rdata
//            shows a WAIT code (2'b10) with the next tag to be issued.
// Ports    : AFT_CLK  clock, rising edge
//            RST      synchronous reset, active-high
//            bus      ahb_ap_resp_buf_if.slave (push/pop/status signals)
// Revision : 1.0 - initial release
// ============================================================================
module ahb_ap_resp_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input  wire                  AFT_CLK,
  input  wire                  RST,
  ahb_ap_resp_buf_if.slave     bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int ENTRY_W = DATA_W + TAG_W + 2;

  localparam logic [1:0] ACK_OK   = 2'b01;
  localparam logic [1:0] ACK_WAIT = 2'b10;
  localparam logic [1:0] ACK_DROP = 2'b11;
  localparam logic [7:0] DROP_MAX = 8'hFF;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]    count_q,    count_d;
  logic             rempty_q,   rempty_d;
  logic             wfull_q,    wfull_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [TAG_W-1:0] tag_next_q, tag_next_d;
  logic             drop_pend_q, drop_pend_d;

  logic             rinc_eff;
  logic             push_ok;
  logic             drop;
  logic [1:0]       ack;

  always_comb begin
    rinc_eff = bus.rinc & ~rempty_q;
    // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
    push_ok  = bus.winc & (~wfull_q | rinc_eff);
    drop     = bus.winc & wfull_q & ~rinc_eff;
    ack      = drop_pend_q ? ACK_DROP : ACK_OK;

    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(rinc_eff);
    count_d  = count_q + CW'(push_ok) - CW'(rinc_eff);
    rempty_d = (count_d == '0);
    wfull_d  = (count_d == FULL_CNT);

    tag_next_d = push_ok ? tag_next_q + TAG_W'(1) : tag_next_q;

    drop_pend_d = drop_pend_q;
    if (push_ok) begin
      drop_pend_d = 1'b0;
    end else if (drop) begin
      drop_pend_d = 1'b1;
    end

    // A drop coinciding with a clear wins: the clear applies first, then the drop counts.
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clr_overflow) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge AFT_CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rempty_q    <= 1'b1;
      wfull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
      tag_next_q  <= '0;
      drop_pend_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rempty_q    <= rempty_d;
      wfull_q     <= wfull_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      tag_next_q  <= tag_next_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge AFT_CLK) begin
    if (!RST && push_ok) begin
      mem_q[wr_ptr_q] <= {ack, tag_next_q, bus.wdata_fifo2};
    end
  end

  assign bus.rdata    = rempty_q ? {ACK_WAIT, tag_next_q, {DATA_W{1'b0}}} : mem_q[rd_ptr_q];
  assign bus.rempty   = rempty_q;
  assign bus.wfull    = wfull_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire
